// File: rtl/n0prime_crt_inv.sv
// ---------------------------------------------------------------------------
// n0prime_crt_inv
//
// Sequential modular-inverse engine for the RSA CRT decryption path.
// Given odd coprime p and q, a start pulse launches two back-to-back runs of
// one binary extended-Euclid unit:
//   INV1 (modulus p): qinv = q^-1 mod p
//   INV2 (modulus q): r    = p^-1 mod q, then t = q - r = (q*qinv - 1)/p
// Results are registered in FIN and announced with a one-cycle done pulse.
//
// Parameters
//   WIDTH   operand/result width in bits (default 512)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset (aborts a running job)
//   start   in   1      request pulse; p,q sampled on this edge (IDLE only)
//   p       in   WIDTH  odd prime p > 1
//   q       in   WIDTH  odd prime q > 1
//   t       out  WIDTH  (q*qinv-1)/p, held between done pulses
//   qinv    out  WIDTH  q^-1 mod p, held between done pulses
//   done    out  1      one-cycle pulse when t/qinv are updated
//   err     out  1      present only with `define N0PRIME_ERR_EN:
//                       1 = invalid input or non-invertible operands
//
// On failure t and qinv are both forced to zero, which is the only failure
// indication when N0PRIME_ERR_EN is not defined.
// ---------------------------------------------------------------------------
module n0prime_crt_inv #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] qinv,
    output logic             done
`ifdef N0PRIME_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INV1 = 2'd1;
    localparam logic [1:0] S_INV2 = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

    // -----------------------------------------------------------------------
    // Modular helpers. Both keep their result in [0, md-1] given inputs in
    // that range and an odd modulus md.
    // -----------------------------------------------------------------------

    // x/2 mod md: an odd x is made even by adding md first. The sum is one
    // bit wider so the carry survives into the shift.
    function automatic logic [WIDTH-1:0] mod_half(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] md
    );
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
        s = s >> 1;
        return s[WIDTH-1:0];
    endfunction

    // (a - b) mod md. When a < b the wrapped difference plus md lands back
    // on the true value, since that value is below md < 2^WIDTH.
    function automatic logic [WIDTH-1:0] mod_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] md
    );
        return (a < b) ? (a - b + md) : (a - b);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] p_q,      p_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic [WIDTH-1:0] u_q,      u_d;
    logic [WIDTH-1:0] v_q,      v_d;
    logic [WIDTH-1:0] x1_q,     x1_d;
    logic [WIDTH-1:0] x2_q,     x2_d;
    logic [WIDTH-1:0] qinv_r_q, qinv_r_d;
    logic [WIDTH-1:0] t_r_q,    t_r_d;
    logic             fail_q,   fail_d;
    logic [WIDTH-1:0] t_q,      t_d;
    logic [WIDTH-1:0] qinv_q,   qinv_d;
    logic             done_q,   done_d;
`ifdef N0PRIME_ERR_EN
    logic             err_q,    err_d;
`endif

    // -----------------------------------------------------------------------
    // Extended-Euclid step unit, shared by INV1 and INV2. Invariants per
    // phase (a = value being inverted): u == x1*a, v == x2*a (mod m).
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] m;
    logic             step_end;
    logic             step_fail;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] u_n, v_n, x1_n, x2_n;
    logic             bad_in;

    always_comb begin
        // INV1 works modulo p, INV2 modulo q; no separate modulus register.
        m         = (state_q == S_INV1) ? p_q : q_q;
        step_end  = (u_q == ONE) || (v_q == ONE);
        // Zero must be caught before the parity tests, otherwise a zero u
        // would be halved forever.
        step_fail = !step_end && ((u_q == ZERO) || (v_q == ZERO));
        step_r    = (u_q == ONE) ? x1_q : x2_q;

        u_n  = u_q;
        v_n  = v_q;
        x1_n = x1_q;
        x2_n = x2_q;
        if (!u_q[0]) begin
            u_n  = u_q >> 1;
            x1_n = mod_half(x1_q, m);
        end else if (!v_q[0]) begin
            v_n  = v_q >> 1;
            x2_n = mod_half(x2_q, m);
        end else if (u_q >= v_q) begin
            u_n  = u_q - v_q;
            x1_n = mod_sub(x1_q, x2_q, m);
        end else begin
            v_n  = v_q - u_q;
            x2_n = mod_sub(x2_q, x1_q, m);
        end

        bad_in = !p[0] || !q[0] || (p < THREE) || (q < THREE);
    end

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        q_d      = q_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        qinv_r_d = qinv_r_q;
        t_r_d    = t_r_q;
        fail_d   = fail_q;
        t_d      = t_q;
        qinv_d   = qinv_q;
        done_d   = 1'b0;
`ifdef N0PRIME_ERR_EN
        err_d    = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d  = p;
                    q_d  = q;
                    u_d  = q;
                    v_d  = p;
                    x1_d = ONE;
                    x2_d = ZERO;
                    if (bad_in) begin
                        fail_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        fail_d  = 1'b0;
                        state_d = S_INV1;
                    end
                end
            end

            S_INV1, S_INV2: begin
                if (step_end) begin
                    if (state_q == S_INV1) begin
                        // Second pass inverts p modulo q.
                        qinv_r_d = step_r;
                        u_d      = p_q;
                        v_d      = q_q;
                        x1_d     = ONE;
                        x2_d     = ZERO;
                        state_d  = S_INV2;
                    end else begin
                        // t = q - p^-1 mod q, i.e. -p^-1 mod q.
                        t_r_d   = (step_r == ZERO) ? ZERO : (q_q - step_r);
                        state_d = S_FIN;
                    end
                end else if (step_fail) begin
                    fail_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    u_d  = u_n;
                    v_d  = v_n;
                    x1_d = x1_n;
                    x2_d = x2_n;
                end
            end

            default: begin // S_FIN
                t_d     = fail_q ? ZERO : t_r_q;
                qinv_d  = fail_q ? ZERO : qinv_r_q;
                done_d  = 1'b1;
`ifdef N0PRIME_ERR_EN
                err_d   = fail_q;
`endif
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            q_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            qinv_r_q <= '0;
            t_r_q    <= '0;
            fail_q   <= 1'b0;
            t_q      <= '0;
            qinv_q   <= '0;
            done_q   <= 1'b0;
`ifdef N0PRIME_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            q_q      <= q_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            qinv_r_q <= qinv_r_d;
            t_r_q    <= t_r_d;
            fail_q   <= fail_d;
            t_q      <= t_d;
            qinv_q   <= qinv_d;
            done_q   <= done_d;
`ifdef N0PRIME_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign t    = t_q;
    assign qinv = qinv_q;
    assign done = done_q;
`ifdef N0PRIME_ERR_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_n0prime_crt_inv.sv
// Bench for n0prime_crt_inv. The reference is a division-based extended
// Euclid over wide integers; one negedge process compares every output on
// every cycle (reset values, hold values, results at done, latency, and the
// identity q*qinv == 1 + t*p), while the driver only issues requests.
module tb_n0prime_crt_inv;

    localparam int W      = 512;
    localparam int BUDGET = 16 * W;

    typedef logic [W-1:0]    word_t;
    typedef logic [1039:0]   wide_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b1;
    logic  start = 1'b0;
    word_t p     = '0;
    word_t q     = '0;
    word_t t;
    word_t qinv;
    logic  done;
`ifdef N0PRIME_ERR_EN
    logic  err;
`endif

    n0prime_crt_inv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .p     (p),
        .q     (q),
        .t     (t),
        .qinv  (qinv),
        .done  (done)
`ifdef N0PRIME_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    // Counters: n_cmp / n_err are stepped only by the compare process.
    int n_cmp = 0;
    int n_err = 0;

    // Request mailbox, written by the driver before each start pulse.
    int    n_issued = 0;
    int    n_done   = 0;
    word_t exp_t, exp_q, exp_p, exp_qq, lit_t, lit_q;
    bit    exp_f, lit_f, lit_en, ident_en;
    int    max_lat;

    // ----------------------------------------------------------------------
    // Reference model: plain extended Euclid with division on wide ints.
    // ----------------------------------------------------------------------
    function automatic void model(input word_t pp, input word_t qq,
                                  output word_t et, output word_t eq,
                                  output bit ef);
        wide_t r0, r1, s0, s1, qt, tmp, bp, bq, prod;
        et = '0;
        eq = '0;
        ef = (pp[0] == 1'b0) || (qq[0] == 1'b0) || (pp < 3) || (qq < 3);
        if (ef) return;
        bp = wide_t'(pp);
        bq = wide_t'(qq);
        r0 = bp;
        r1 = bq % bp;
        s0 = '0;
        s1 = wide_t'(1);
        while (r1 != 0) begin
            qt  = r0 / r1;
            tmp = r0 - qt * r1;
            r0  = r1;
            r1  = tmp;
            tmp = (s0 + bp - ((qt * s1) % bp)) % bp;
            s0  = s1;
            s1  = tmp;
        end
        if (r0 != 1) begin
            ef = 1'b1;
            return;
        end
        eq   = s0[W-1:0];
        prod = (bq * s0 - 1) / bp;
        et   = prod[W-1:0];
    endfunction

    task automatic chk(input string name, input word_t act, input word_t expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ----------------------------------------------------------------------
    // Compare process
    // ----------------------------------------------------------------------
    int    cyc = 0;
    bit    active = 1'b0;
    int    wait_cnt = 0;
    word_t cur_t = '0, cur_q = '0;
    bit    cur_f = 1'b0;

    always @(negedge clk) begin
        word_t mt, mq;
        bit    mf;
        logic [1023:0] lhs, rhs;
        cyc++;
        if (cyc == 2) begin
            // Pin the model to hand-derived values.
            model(W'(59), W'(97), mt, mq, mf);
            chk("model_59_97_qinv", mq, W'(14));
            chk("model_59_97_t", mt, W'(23));
            model(W'(97), W'(59), mt, mq, mf);
            chk("model_97_59_qinv", mq, W'(74));
            chk("model_97_59_t", mt, W'(45));
            model(W'(3), W'(5), mt, mq, mf);
            chk("model_3_5_qinv", mq, W'(2));
            chk("model_3_5_t", mt, W'(3));
            model(W'(15), W'(21), mt, mq, mf);
            chk("model_15_21_fail", W'(mf), W'(1));
        end
        if (!rst_n) begin
            chk("rst_t", t, '0);
            chk("rst_qinv", qinv, '0);
            chk("rst_done", W'(done), '0);
`ifdef N0PRIME_ERR_EN
            chk("rst_err", W'(err), '0);
`endif
            cur_t  = '0;
            cur_q  = '0;
            cur_f  = 1'b0;
            active = 1'b0;
        end else begin
            if (start && (n_issued > n_done) && !active) begin
                active   = 1'b1;
                wait_cnt = 0;
            end else if (active) begin
                wait_cnt++;
            end
            if (done) begin
                n_cmp++;
                if (n_issued <= n_done) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    chk("done_t", t, exp_t);
                    chk("done_qinv", qinv, exp_q);
`ifdef N0PRIME_ERR_EN
                    chk("done_err", W'(err), W'(exp_f));
`endif
                    if (lit_en) begin
                        chk("lit_t", t, lit_t);
                        chk("lit_qinv", qinv, lit_q);
`ifdef N0PRIME_ERR_EN
                        chk("lit_err", W'(err), W'(lit_f));
`endif
                    end
                    n_cmp++;
                    if (wait_cnt > max_lat) begin
                        n_err++;
                        $display("FAIL latency: got %0d cycles required <= %0d", wait_cnt, max_lat);
                    end
                    if (ident_en) begin
                        lhs = 1024'(exp_qq) * 1024'(qinv);
                        rhs = 1024'(1) + 1024'(t) * 1024'(exp_p);
                        n_cmp++;
                        if (lhs !== rhs || !(qinv < exp_p) || !(t < exp_qq)) begin
                            n_err++;
                            $display("FAIL identity: got qinv=%0h t=%0h for p=%0h q=%0h", qinv, t, exp_p, exp_qq);
                        end
                    end
                    cur_t  = exp_t;
                    cur_q  = exp_q;
                    cur_f  = exp_f;
                    n_done = n_done + 1;
                    active = 1'b0;
                end
            end else begin
                chk("hold_t", t, cur_t);
                chk("hold_qinv", qinv, cur_q);
`ifdef N0PRIME_ERR_EN
                chk("hold_err", W'(err), W'(cur_f));
`endif
                if (active && wait_cnt > BUDGET) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL timeout: got no done after %0d cycles required <= %0d", wait_cnt, BUDGET);
                    n_done = n_done + 1;
                    active = 1'b0;
                end
            end
        end
    end

    // ----------------------------------------------------------------------
    // Driver
    // ----------------------------------------------------------------------
    task automatic issue(input word_t pp, input word_t qq, input bit le,
                         input word_t lt, input word_t lq, input bit lf,
                         input int maxl, input bit ident);
        word_t mt, mq;
        bit    mf;
        model(pp, qq, mt, mq, mf);
        exp_t = mt; exp_q = mq; exp_f = mf; exp_p = pp; exp_qq = qq;
        lit_en = le; lit_t = lt; lit_q = lq; lit_f = lf;
        max_lat = maxl; ident_en = ident;
        @(posedge clk); #1;
        n_issued = n_done + 1;
        p = pp; q = qq; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // The compare process retires every request (done or timeout), so this
    // is bounded; the guard is a second line of defence.
    task automatic wait_idle();
        int guard = 0;
        while (n_done < n_issued && guard < BUDGET + 100) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
    endtask

    function automatic word_t rnd_odd();
        word_t v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        v[W-1] = 1'b1;
        v[0]   = 1'b1;
        return v;
    endfunction

    initial begin
        word_t rp, rq, mt, mq;
        bit    mf;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vectors with hand-computed results.
        issue(W'(59), W'(97), 1'b1, W'(23), W'(14), 1'b0, 2054, 1'b1); wait_idle();
        issue(W'(97), W'(59), 1'b1, W'(45), W'(74), 1'b0, 2054, 1'b1); wait_idle();
        issue(W'(3),  W'(5),  1'b1, W'(3),  W'(2),  1'b0, 2054, 1'b1); wait_idle();
        issue(W'(15), W'(21), 1'b1, W'(0),  W'(0),  1'b1, 2054, 1'b0); wait_idle();
        issue(W'(58), W'(97), 1'b1, W'(0),  W'(0),  1'b1, 4,    1'b0); wait_idle();

        // Reset a few steps into INV1: outputs clear, no done follows.
        issue(W'(59), W'(97), 1'b1, W'(23), W'(14), 1'b0, 2054, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_issued = n_done;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);

        // Restart, with a second start during INV1 that must be ignored.
        issue(W'(59), W'(97), 1'b1, W'(23), W'(14), 1'b0, 2054, 1'b1);
        repeat (2) @(posedge clk);
        #1 p = W'(3); q = W'(5); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (50) @(posedge clk);

        // Random full-width odd coprime operands.
        for (int k = 0; k < 2; k++) begin
            for (int tries = 0; tries < 50; tries++) begin
                rp = rnd_odd();
                rq = rnd_odd();
                model(rp, rq, mt, mq, mf);
                if (!mf) break;
            end
            issue(rp, rq, 1'b0, '0, '0, 1'b0, BUDGET, 1'b1);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
